// File: rtl/cp0_regfile.sv
// CP0 register file (Status/Cause/EPC) with exception entry, ERET and a fetch redirect handshake.
// Define CP0_INT_SYNC_EN to pass hw_int through a 2-flop synchroniser before Cause.IP_hw.
module cp0_regfile #(
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0080,
    parameter logic [31:0] RESET_STATUS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pendingexception,
    input  logic [4:0]  exccode,
    input  logic [31:0] epc_in,
    input  logic        in_delay_slot,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [5:0]  hw_int,
    output logic        iec,
    output logic [7:0]  interrupts,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);
    // state    | meaning
    // IDLE     | accepting exception, eret and mtc0
    // REDIRECT | redirect_valid high, waiting for redirect_ready
    typedef enum logic {S_IDLE, S_REDIRECT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  im_q, im_d;
    logic [5:0]  stk_q, stk_d;
    logic        bd_q, bd_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] rpc_q, rpc_d;
    logic [5:0]  ip_hw_q;
    logic [31:0] status_w, cause_w;

    assign status_w = {16'h0000, im_q, 2'b00, stk_q};
    assign cause_w  = {bd_q, 15'h0000, ip_hw_q, ip_sw_q, 1'b0, exc_q, 2'b00};

    always_comb begin
        state_d = state_q;
        im_d    = im_q;
        stk_d   = stk_q;
        bd_d    = bd_q;
        ip_sw_d = ip_sw_q;
        exc_d   = exc_q;
        epc_d   = epc_q;
        rpc_d   = rpc_q;
        case (state_q)
            S_IDLE: begin
                if (pendingexception) begin
                    state_d = S_REDIRECT;
                    rpc_d   = EXC_VECTOR;
                    epc_d   = in_delay_slot ? (epc_in - 32'd4) : epc_in;
                    bd_d    = in_delay_slot;
                    exc_d   = exccode;
                    stk_d   = {stk_q[3:0], 2'b00};
                end else if (eret) begin
                    state_d = S_REDIRECT;
                    rpc_d   = epc_q;
                    stk_d   = {stk_q[5:4], stk_q[5:2]};
                end else if (mtc0_we) begin
                    case (cp0_addr)
                        5'd12: begin
                            im_d  = wdata[15:8];
                            stk_d = wdata[5:0];
                        end
                        5'd13:   ip_sw_d = wdata[9:8];
                        5'd14:   epc_d   = wdata;
                        default: ;
                    endcase
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            im_q    <= RESET_STATUS[15:8];
            stk_q   <= RESET_STATUS[5:0];
            bd_q    <= 1'b0;
            ip_sw_q <= 2'b00;
            exc_q   <= 5'd0;
            epc_q   <= 32'd0;
            rpc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            im_q    <= im_d;
            stk_q   <= stk_d;
            bd_q    <= bd_d;
            ip_sw_q <= ip_sw_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
            rpc_q   <= rpc_d;
        end
    end

`ifdef CP0_INT_SYNC_EN
    logic [5:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 6'd0;
            sync2_q <= 6'd0;
            ip_hw_q <= 6'd0;
        end else begin
            sync1_q <= hw_int;
            sync2_q <= sync1_q;
            ip_hw_q <= sync2_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ip_hw_q <= 6'd0;
        else        ip_hw_q <= hw_int;
    end
`endif

    always_comb begin
        rdata = 32'd0;
        case (cp0_addr)
            5'd12:   rdata = status_w;
            5'd13:   rdata = cause_w;
            5'd14:   rdata = epc_q;
            default: rdata = 32'd0;
        endcase
    end

    assign iec            = stk_q[0];
    assign redirect_valid = (state_q == S_REDIRECT);
    assign redirect_pc    = rpc_q;
    // Fetch is being steered away, so no interrupt is reported meanwhile
    assign interrupts     = redirect_valid ? 8'h00 : ({ip_hw_q, ip_sw_q} & im_q);
endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus a randomized run against a reference model.
module tb_cp0_regfile;
    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0080;
    localparam logic [31:0] RESET_STATUS = 32'h0000_0000;
`ifdef CP0_INT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pendingexception = 1'b0;
    logic [4:0]  exccode = 5'd0;
    logic [31:0] epc_in = 32'd0;
    logic        in_delay_slot = 1'b0;
    logic        eret = 1'b0;
    logic        mtc0_we = 1'b0;
    logic [4:0]  cp0_addr = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic [5:0]  hw_int = 6'd0;
    logic        iec;
    logic [7:0]  interrupts;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    cp0_regfile #(.EXC_VECTOR(EXC_VECTOR), .RESET_STATUS(RESET_STATUS)) dut (
        .clk(clk), .rst_n(rst_n), .pendingexception(pendingexception), .exccode(exccode),
        .epc_in(epc_in), .in_delay_slot(in_delay_slot), .eret(eret), .mtc0_we(mtc0_we),
        .cp0_addr(cp0_addr), .wdata(wdata), .rdata(rdata), .hw_int(hw_int), .iec(iec),
        .interrupts(interrupts), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register values plus a busy flag for the pending redirect
    logic [31:0] m_status, m_epc, m_rpc;
    logic        m_bd, m_busy;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  hist [3];

    function automatic void model_reset();
        m_status = RESET_STATUS & 32'h0000_FF3F;
        m_epc = 0; m_rpc = 0; m_bd = 0; m_busy = 0; m_exc = 0; m_ipsw = 0;
        for (int i = 0; i < 3; i++) hist[i] = 6'd0;
    endfunction

    function automatic logic [5:0] m_iphw();
        return hist[LAT-1];
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) | (32'(m_iphw()) << 10) | (32'(m_ipsw) << 8) | (32'(m_exc) << 2);
    endfunction

    function automatic logic [7:0] m_ints();
        logic [7:0] ip;
        if (m_busy) return 8'h00;
        ip = 8'((int'(m_iphw()) * 4) + int'(m_ipsw));
        return ip & m_status[15:8];
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        if (a == 5'd12) return m_status;
        if (a == 5'd13) return m_cause();
        if (a == 5'd14) return m_epc;
        return 32'd0;
    endfunction

    function automatic void model_edge();
        int lo;
        lo = int'(m_status[5:0]);
        if (!m_busy) begin
            if (pendingexception) begin
                m_busy = 1; m_rpc = EXC_VECTOR;
                m_epc = in_delay_slot ? epc_in - 32'd4 : epc_in;
                m_bd = in_delay_slot; m_exc = exccode;
                lo = (lo * 4) % 64;
            end else if (eret) begin
                m_busy = 1; m_rpc = m_epc;
                lo = (lo & 48) | (lo / 4);
            end else if (mtc0_we) begin
                if (cp0_addr == 5'd12) begin
                    m_status = wdata & 32'h0000_FF3F;
                    lo = int'(wdata[5:0]);
                end else if (cp0_addr == 5'd13) m_ipsw = wdata[9:8];
                else if (cp0_addr == 5'd14) m_epc = wdata;
            end
        end else if (redirect_ready) m_busy = 0;
        m_status[5:0] = 6'(lo);
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = hw_int;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pendingexception = 0; eret = 0; mtc0_we = 0; in_delay_slot = 0; redirect_ready = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a;
        #1 d = rdata;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        idle_inputs();
        mtc0_we = 1; cp0_addr = a; wdata = d;
        tick();
        mtc0_we = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 0; model_reset();
        #12;
        rd(5'd12, d); n_cmp++;
        if (d !== RESET_STATUS) begin n_fail++; $display("FAIL reset_status got %h exp %h", d, RESET_STATUS); end
        rd(5'd13, d); n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_cause got %h exp 0", d); end
        rd(5'd14, d); n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_epc got %h exp 0", d); end
        n_cmp++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || interrupts !== 8'd0) begin
            n_fail++; $display("FAIL reset_outputs got v=%b pc=%h int=%h exp 0/0/0", redirect_valid, redirect_pc, interrupts);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_exception();
        logic [31:0] d;
        write_reg(5'd12, 32'h0000_FF01);
        pendingexception = 1; exccode = 5'd8; epc_in = 32'h0040_0010; in_delay_slot = 0; redirect_ready = 0;
        tick();
        pendingexception = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0080) begin
                n_fail++; $display("FAIL exc_hold cyc%0d got v=%b pc=%h exp 1/80000080", i, redirect_valid, redirect_pc);
            end
            tick();
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        n_cmp++;
        if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL exc_release got v=%b exp 0", redirect_valid); end
        rd(5'd14, d); n_cmp++;
        if (d !== 32'h0040_0010) begin n_fail++; $display("FAIL exc_epc got %h exp 00400010", d); end
        rd(5'd13, d); n_cmp++;
        if (d[6:2] !== 5'd8 || d[31] !== 1'b0) begin n_fail++; $display("FAIL exc_cause got %h exp code 8 bd 0", d); end
        rd(5'd12, d); n_cmp++;
        if (d !== 32'h0000_FF04) begin n_fail++; $display("FAIL exc_status got %h exp 0000ff04", d); end
        n_cmp++;
        if (iec !== 1'b0) begin n_fail++; $display("FAIL exc_iec got %b exp 0", iec); end
    endtask

    task automatic test_delay_slot();
        logic [31:0] d;
        idle_inputs();
        pendingexception = 1; exccode = 5'd4; epc_in = 32'h0040_0024; in_delay_slot = 1; redirect_ready = 1;
        tick();
        pendingexception = 0; in_delay_slot = 0;
        n_cmp++;
        if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL ds_valid got %b exp 1", redirect_valid); end
        tick();
        n_cmp++;
        if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ds_one_cycle got %b exp 0", redirect_valid); end
        redirect_ready = 0;
        rd(5'd14, d); n_cmp++;
        if (d !== 32'h0040_0020) begin n_fail++; $display("FAIL ds_epc got %h exp 00400020", d); end
        rd(5'd13, d); n_cmp++;
        if (d[31] !== 1'b1) begin n_fail++; $display("FAIL ds_bd got %b exp 1", d[31]); end
    endtask

    task automatic test_eret();
        logic [31:0] d;
        write_reg(5'd12, 32'h0000_FF04);
        eret = 1;
        tick();
        eret = 0;
        n_cmp++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0020) begin
            n_fail++; $display("FAIL eret_pc got v=%b pc=%h exp 1/00400020", redirect_valid, redirect_pc);
        end
        redirect_ready = 1; tick(); redirect_ready = 0;
        rd(5'd12, d); n_cmp++;
        if (d[5:0] !== 6'h01) begin n_fail++; $display("FAIL eret_status got %h exp 01", d[5:0]); end
        n_cmp++;
        if (iec !== 1'b1) begin n_fail++; $display("FAIL eret_iec got %b exp 1", iec); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        write_reg(5'd12, 32'h0000_FF01);
        pendingexception = 1; exccode = 5'd12; epc_in = 32'h0040_0100; in_delay_slot = 0;
        eret = 1; mtc0_we = 1; cp0_addr = 5'd12; wdata = 32'h0000_0033;
        tick();
        eret = 0; mtc0_we = 0;
        n_cmp++;
        if (redirect_pc !== EXC_VECTOR) begin n_fail++; $display("FAIL prio_pc got %h exp %h", redirect_pc, EXC_VECTOR); end
        exccode = 5'd3; epc_in = 32'h0000_1234;
        tick();
        pendingexception = 0; redirect_ready = 1;
        tick();
        redirect_ready = 0;
        rd(5'd14, d); n_cmp++;
        if (d !== 32'h0040_0100) begin n_fail++; $display("FAIL prio_epc got %h exp 00400100", d); end
        rd(5'd13, d); n_cmp++;
        if (d[6:2] !== 5'd12) begin n_fail++; $display("FAIL prio_code got %0d exp 12", d[6:2]); end
        rd(5'd12, d); n_cmp++;
        if (d !== 32'h0000_FF04) begin n_fail++; $display("FAIL prio_status got %h exp 0000ff04", d); end
    endtask

    task automatic test_interrupts();
        write_reg(5'd12, 32'h0000_FF01);
        hw_int = 6'b000001;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            n_cmp++;
            if (interrupts !== ((i == LAT) ? 8'h04 : 8'h00)) begin
                n_fail++; $display("FAIL int_latency cyc%0d got %h exp %h", i, interrupts, (i == LAT) ? 8'h04 : 8'h00);
            end
        end
        pendingexception = 1; tick(); pendingexception = 0;
        n_cmp++;
        if (interrupts !== 8'h00) begin n_fail++; $display("FAIL int_redirect got %h exp 00", interrupts); end
        redirect_ready = 1; tick(); redirect_ready = 0;
        n_cmp++;
        if (interrupts !== 8'h04) begin n_fail++; $display("FAIL int_after got %h exp 04", interrupts); end
        hw_int = 6'd0;
        for (int i = 0; i < LAT; i++) tick();
    endtask

    task automatic test_reset_mid_redirect();
        pendingexception = 1; exccode = 5'd9; epc_in = 32'h0040_0400;
        tick();
        pendingexception = 0;
        rst_n = 0; model_reset();
        #1;
        n_cmp++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin
            n_fail++; $display("FAIL rst_abort got v=%b pc=%h exp 0/0", redirect_valid, redirect_pc);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [4:0] addrs [4];
        addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'd0;
        for (int c = 0; c < 600; c++) begin
            pendingexception = ($urandom_range(0, 7) == 0);
            eret             = ($urandom_range(0, 6) == 0);
            mtc0_we          = ($urandom_range(0, 3) == 0);
            exccode          = 5'($urandom);
            epc_in           = $urandom;
            in_delay_slot    = 1'($urandom);
            wdata            = $urandom;
            redirect_ready   = 1'($urandom);
            cp0_addr         = ($urandom_range(0, 4) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
            tick();
            #1;
            n_cmp++;
            if (redirect_valid !== m_busy || redirect_pc !== m_rpc || interrupts !== m_ints()
                || iec !== m_status[0] || rdata !== m_rdata(cp0_addr)) begin
                n_fail++;
                $display("FAIL rand cyc%0d got v=%b pc=%h int=%h iec=%b rd=%h exp v=%b pc=%h int=%h iec=%b rd=%h",
                         c, redirect_valid, redirect_pc, interrupts, iec, rdata,
                         m_busy, m_rpc, m_ints(), m_status[0], m_rdata(cp0_addr));
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_delay_slot();
        test_eret();
        test_priority();
        test_interrupts();
        test_reset_mid_redirect();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
